// File: rtl/i2c_write_sequencer_if.sv
// Signal bundle between host logic, the write sequencer and the I2C bit engine.
// master: the sequencer side; slave: the host/engine side that drives requests and responses.
interface i2c_write_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_data;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_stop;
    logic       byte_done;
    logic       byte_nack;

    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] retry_cnt;

    modport master (
        input  req_valid, req_dev_addr, req_reg_addr, req_data,
        output req_ready,
        output tx_valid, tx_byte, tx_start, tx_stop,
        input  tx_ready, byte_done, byte_nack,
        output busy, done, error, retry_cnt
    );

    modport slave (
        output req_valid, req_dev_addr, req_reg_addr, req_data,
        input  req_ready,
        input  tx_valid, tx_byte, tx_start, tx_stop,
        output tx_ready, byte_done, byte_nack,
        input  busy, done, error, retry_cnt
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Register-write transaction controller: issues addr+W / reg / data bytes to the I2C bit
// engine, checks each ACK slot and retries the whole transaction on NACK or timeout.
module i2c_write_sequencer #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned GAP_CYC     = 5000
) (
    input logic                   clk,
    input logic                   reset,
    i2c_write_sequencer_if.master bus
);

    localparam int unsigned CntMax    = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned RetryBits = $clog2(MAX_RETRY + 1);
    localparam int unsigned RetryW    = (RetryBits > 2) ? RetryBits : 2;

    localparam logic [CntW-1:0]   TimeoutLast = CntW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CntW-1:0]   GapLast     = CntW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);
    localparam logic [RetryW-1:0] RetrySat    = RetryW'(3);

    typedef enum logic [3:0] {
        StIdle,
        StIssueAddr,
        StWaitAddr,
        StIssueReg,
        StWaitReg,
        StIssueData,
        StWaitData,
        StFail,
        StGap,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [6:0]        dev_q;
    logic [7:0]        reg_q;
    logic [7:0]        data_q;

    logic accept;
    logic byte_ok;
    logic byte_bad;
    logic can_retry;
    logic counting;

    assign accept    = (state_q == StIdle) && bus.req_valid;
    assign byte_ok   = bus.byte_done && !bus.byte_nack;
    // A real byte_done in the final timeout cycle takes priority over the timeout.
    assign byte_bad  = (bus.byte_done && bus.byte_nack) ||
                       (!bus.byte_done && (cnt_q == TimeoutLast));
    assign can_retry = (retry_q < RetryMax);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dev_q  <= '0;
            reg_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            dev_q  <= bus.req_dev_addr;
            reg_q  <= bus.req_reg_addr;
            data_q <= bus.req_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        counting = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    retry_d = '0;
                    state_d = StIssueAddr;
                end
            end
            StIssueAddr: if (bus.tx_ready) state_d = StWaitAddr;
            StWaitAddr: begin
                counting = 1'b1;
                if (byte_ok) state_d = StIssueReg;
                else if (byte_bad) state_d = StFail;
            end
            StIssueReg: if (bus.tx_ready) state_d = StWaitReg;
            StWaitReg: begin
                counting = 1'b1;
                if (byte_ok) state_d = StIssueData;
                else if (byte_bad) state_d = StFail;
            end
            StIssueData: if (bus.tx_ready) state_d = StWaitData;
            StWaitData: begin
                counting = 1'b1;
                if (byte_ok) state_d = StFinish;
                else if (byte_bad) state_d = StFail;
            end
            StFail: begin
                if (can_retry) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StGap;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                counting = 1'b1;
                if (cnt_q == GapLast) state_d = StIssueAddr;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Counter runs only while parked in a wait/gap state, so it restarts at 0 on entry.
        cnt_d = (counting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.tx_valid  = 1'b0;
        bus.tx_byte   = 8'h00;
        bus.tx_start  = 1'b0;
        bus.tx_stop   = 1'b0;
        unique case (state_q)
            StIssueAddr: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = {dev_q, 1'b0};
                bus.tx_start = 1'b1;
            end
            StIssueReg: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = reg_q;
            end
            StIssueData: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = data_q;
                bus.tx_stop  = 1'b1;
            end
            default: ;
        endcase
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StFinish);
        bus.error     = (state_q == StFail) && !can_retry;
        bus.retry_cnt = (retry_q > RetrySat) ? 2'd3 : retry_q[1:0];
    end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench: a behavioural engine answers the sequencer, a monitor pops expectations
// whenever a byte handshake, retry restart or done/error pulse appears.
module tb_i2c_write_sequencer;

    localparam int unsigned MaxRetry   = 3;
    localparam int unsigned TimeoutCyc = 100;
    localparam int unsigned GapCyc     = 5000;
    localparam logic [16:0] RstExp     = {1'b1, 16'h0000};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_write_sequencer_if bus ();

    i2c_write_sequencer #(
        .MAX_RETRY  (MaxRetry),
        .TIMEOUT_CYC(TimeoutCyc),
        .GAP_CYC    (GapCyc)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int main_timeouts = 0;
    bit end_req = 1'b0;
    bit end_ack = 1'b0;

    // Engine behaviour knobs
    int          ready_delay_reg = 0;
    int          done_delay = 0;
    bit          silent = 1'b0;
    logic [31:0] nack_plan = 32'h0;

    logic [9:0] exp_tx[$];   // {byte, start, stop}
    logic [3:0] exp_evt[$];  // {done, error, retry_cnt}
    int         exp_gap[$];  // cycles from last handshake/byte_done to retry restart

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    initial begin : engine
        bit inflight, hs, cur_start, nack;
        int dly, rdy_cnt, idx, attempt;
        inflight = 0; hs = 0; cur_start = 0; nack = 0;
        dly = 0; rdy_cnt = 0; idx = 0; attempt = 0;
        bus.tx_ready = 1'b0;
        bus.byte_done = 1'b0;
        bus.byte_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.byte_done = 1'b0;
            bus.byte_nack = 1'b0;
            if (!rst_n) begin
                bus.tx_ready = 1'b0;
                inflight = 0; hs = 0; rdy_cnt = 0; idx = 0; attempt = 0;
            end else begin
                if (bus.done || bus.error) attempt = 0;
                if (hs) begin
                    bus.tx_ready = 1'b0;
                    rdy_cnt = 0;
                    if (cur_start) begin
                        idx = 0;
                        attempt++;
                    end else begin
                        idx++;
                    end
                    inflight = 1;
                    dly = done_delay;
                    nack = nack_plan[(attempt - 1) * 3 + idx];
                end
                if (inflight && !silent) begin
                    if (dly == 0) begin
                        bus.byte_done = 1'b1;
                        bus.byte_nack = nack;
                        inflight = 0;
                    end else begin
                        dly--;
                    end
                end
                if (bus.tx_valid) begin
                    if (!bus.tx_start && !bus.tx_stop && rdy_cnt < ready_delay_reg) begin
                        bus.tx_ready = 1'b0;
                        rdy_cnt++;
                    end else begin
                        bus.tx_ready = 1'b1;
                    end
                end else begin
                    bus.tx_ready = 1'b0;
                end
                hs = bus.tx_valid && bus.tx_ready;
                cur_start = bus.tx_start;
            end
        end
    end

    initial begin : monitor
        bit prev_valid, prev_hs, rst_seen, idle_chk;
        logic [9:0] prev_tx;
        logic [9:0] etx;
        logic [3:0] eevt;
        int cyc, ref_cyc, attempts, egap;
        prev_valid = 0; prev_hs = 0; rst_seen = 0; idle_chk = 0;
        prev_tx = '0; cyc = 0; ref_cyc = 0; attempts = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                if (!rst_seen)
                    check("reset_outputs", 32'({bus.req_ready, bus.tx_valid, bus.tx_start,
                          bus.tx_stop, bus.busy, bus.done, bus.error, bus.tx_byte,
                          bus.retry_cnt}), 32'(RstExp));
                rst_seen = 1; prev_valid = 0; prev_hs = 0; attempts = 0; idle_chk = 0;
            end else begin
                rst_seen = 0;
                if (idle_chk) check("idle_after_end", 32'({bus.req_ready, bus.busy}), 32'h2);
                idle_chk = 0;
                if (prev_valid && !prev_hs)
                    check("tx_hold", 32'({bus.tx_valid, bus.tx_byte, bus.tx_start, bus.tx_stop}),
                          32'({1'b1, prev_tx}));
                if (bus.tx_valid && !prev_valid && bus.tx_start && attempts > 0) begin
                    if (exp_gap.size() == 0) note_fail("retry_unexpected", 32'(cyc - ref_cyc));
                    else begin
                        egap = exp_gap.pop_front();
                        check("retry_gap", 32'(cyc - ref_cyc), 32'(egap));
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_tx.size() == 0)
                        note_fail("tx_unexpected", 32'({bus.tx_byte, bus.tx_start, bus.tx_stop}));
                    else begin
                        etx = exp_tx.pop_front();
                        check("tx_byte", 32'({bus.tx_byte, bus.tx_start, bus.tx_stop}), 32'(etx));
                    end
                    ref_cyc = cyc;
                    if (bus.tx_start) attempts++;
                end
                if (bus.byte_done) ref_cyc = cyc;
                if (bus.done || bus.error) begin
                    if (exp_evt.size() == 0)
                        note_fail("result_unexpected",
                                  32'({bus.done, bus.error, bus.retry_cnt}));
                    else begin
                        eevt = exp_evt.pop_front();
                        check("txn_result", 32'({bus.done, bus.error, bus.retry_cnt}), 32'(eevt));
                    end
                    attempts = 0;
                    idle_chk = 1;
                end
                prev_valid = bus.tx_valid;
                prev_hs = bus.tx_valid && bus.tx_ready;
                prev_tx = {bus.tx_byte, bus.tx_start, bus.tx_stop};
            end
            if (end_req && !end_ack) begin
                check("leftover_tx", 32'(exp_tx.size()), 32'h0);
                check("leftover_result", 32'(exp_evt.size()), 32'h0);
                check("leftover_gap", 32'(exp_gap.size()), 32'h0);
                check("main_timeouts", 32'(main_timeouts), 32'h0);
                end_ack = 1;
            end
        end
    end

    task automatic push_tx(input logic [7:0] b, input logic s, input logic p);
        exp_tx.push_back({b, s, p});
    endtask

    task automatic push_evt(input logic is_err, input logic [1:0] rc);
        exp_evt.push_back({!is_err, is_err, rc});
    endtask

    task automatic send(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dat);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_dev_addr = dev;
        bus.req_reg_addr = rg;
        bus.req_data = dat;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        bit ok;
        do begin
            @(posedge clk);
            #1;
            n++;
            ok = (exp_tx.size() == 0) && (exp_evt.size() == 0) && !bus.busy;
        end while (!ok && n < limit);
        if (!ok) begin
            main_timeouts++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_dev_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_data = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Happy path
        push_tx(8'hA0, 1, 0); push_tx(8'h10, 0, 0); push_tx(8'hA5, 0, 1);
        push_evt(0, 2'd0);
        send(7'h50, 8'h10, 8'hA5);
        wait_idle("happy", 200);

        // NACK on data byte of the first attempt only
        nack_plan = 32'h0000_0004;
        push_tx(8'hA0, 1, 0); push_tx(8'h10, 0, 0); push_tx(8'hA5, 0, 1);
        exp_gap.push_back(GapCyc + 2);
        push_tx(8'hA0, 1, 0); push_tx(8'h10, 0, 0); push_tx(8'hA5, 0, 1);
        push_evt(0, 2'd1);
        send(7'h50, 8'h10, 8'hA5);
        wait_idle("nack_data", 20000);

        // Persistent NACK on address byte: four address issues then error
        nack_plan = 32'h0000_0249;
        for (int i = 0; i < 4; i++) begin
            push_tx(8'h54, 1, 0);
            if (i > 0) exp_gap.push_back(GapCyc + 2);
        end
        push_evt(1, 2'd3);
        send(7'h2A, 8'h33, 8'h44);
        wait_idle("nack_addr", 25000);
        nack_plan = 32'h0;

        // Engine never answers: timeout-driven retries
        silent = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_tx(8'hA0, 1, 0);
            if (i > 0) exp_gap.push_back(TimeoutCyc + GapCyc + 2);
        end
        push_evt(1, 2'd3);
        send(7'h50, 8'h10, 8'hA5);
        wait_idle("timeout", 25000);
        silent = 1'b0;

        // Back-pressure on the register byte, plus a request while busy
        ready_delay_reg = 20;
        push_tx(8'hA0, 1, 0); push_tx(8'h10, 0, 0); push_tx(8'h3C, 0, 1);
        push_evt(0, 2'd0);
        send(7'h50, 8'h10, 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_dev_addr = 7'h11;
        bus.req_reg_addr = 8'h99;
        bus.req_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_idle("backpressure", 500);
        ready_delay_reg = 0;

        // Reset while waiting on the register byte's ACK slot
        done_delay = 40;
        push_tx(8'hA0, 1, 0); push_tx(8'h22, 0, 0);
        send(7'h50, 8'h22, 8'h77);
        n = 0;
        while (exp_tx.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_tx.size() != 0) begin
            main_timeouts++;
            $display("FAIL reg_issue: %0d bytes pending, expected 0", exp_tx.size());
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        done_delay = 0;

        // Normal request after the mid-transaction reset
        push_tx(8'h76, 1, 0); push_tx(8'h01, 0, 0); push_tx(8'hFF, 0, 1);
        push_evt(0, 2'd0);
        send(7'h3B, 8'h01, 8'hFF);
        wait_idle("after_reset", 200);

        end_req = 1'b1;
        n = 0;
        while (!end_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
